// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: loads DEPTH words, bubble-sorts them with one shared comparator, streams them out ascending.
// Define CMP_SORT_EARLY_EXIT_EN to leave SORT after the first pass that makes no swap.
module cmp_sort_ctrl #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [2:0]       cmp_out,
    output logic [7:0]       swap_count
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] last_idx = IW'(DEPTH - 1);
    localparam logic [IW-1:0] last_pass = IW'(DEPTH - 2);
    typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0] wr_idx, rd_idx, p, j, j1;
    logic [WIDTH-1:0] a, b;
    logic swapped, gt, eq, lt, end_pass, done;

    assign j1 = j + 1'b1;
    assign a = mem[j];
    assign b = mem[j1];
    assign gt = a > b;
    assign eq = a == b;
    assign lt = a < b;
    assign end_pass = j == last_pass - p;
    assign out_data = mem[rd_idx];
`ifdef CMP_SORT_EARLY_EXIT_EN
    // The swap made on the last compare of the pass still counts as a swap in that pass.
    assign done = end_pass && (p == last_pass || !(swapped || gt));
`else
    assign done = end_pass && p == last_pass;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= LOAD;
        else     state <= state_nx;

    always_comb begin
        state_nx  = state;
        in_ready  = state == LOAD;
        out_valid = state == OUT;
        busy      = state == SORT;
        cmp_out   = state == SORT ? {gt, eq, lt} : 3'b000;
        case (state)
            LOAD:    if (in_valid && wr_idx == last_idx) state_nx = SORT;
            SORT:    if (done) state_nx = OUT;
            OUT:     if (out_ready && rd_idx == last_idx) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_idx     <= '0;
            rd_idx     <= '0;
            p          <= '0;
            j          <= '0;
            swapped    <= 1'b0;
            swap_count <= '0;
        end else begin
            if (state == LOAD && in_valid) begin
                mem[wr_idx] <= in_data;
                wr_idx      <= wr_idx == last_idx ? '0 : wr_idx + 1'b1;
                if (wr_idx == last_idx) begin
                    p          <= '0;
                    j          <= '0;
                    swapped    <= 1'b0;
                    swap_count <= '0;
                end
            end
            if (state == SORT) begin
                if (gt) begin
                    mem[j]     <= b;
                    mem[j1]    <= a;
                    swap_count <= swap_count + {7'd0, swap_count != 8'hff};
                end
                swapped <= end_pass ? 1'b0 : swapped | gt;
                j       <= end_pass ? '0 : j1;
                p       <= end_pass ? p + 1'b1 : p;
                rd_idx  <= '0;
            end
            if (state == OUT && out_ready) rd_idx <= rd_idx == last_idx ? '0 : rd_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb_cmp_sort_ctrl: table vectors, corner sequences and random blocks against a sorting reference model.
module tb_cmp_sort_ctrl;
    typedef logic [3:0][1:0] blk_t;
    typedef struct {
        string nm;
        blk_t  w;
        blk_t  e;
        int    sw;
        int    cyc;
        int    stall;
    } vec_t;
`ifdef CMP_SORT_EARLY_EXIT_EN
    localparam bit early = 1'b1;
`else
    localparam bit early = 1'b0;
`endif

    logic clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [1:0] in_data, out_data;
    logic [2:0] cmp_out;
    logic [7:0] swap_count;
    int checks = 0, errors = 0;
    vec_t tbl[4];

    cmp_sort_ctrl #(.WIDTH(2), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .cmp_out(cmp_out), .swap_count(swap_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic blk_t mk(input int a, input int b, input int c, input int d);
        blk_t r;
        r[0] = 2'(a);
        r[1] = 2'(b);
        r[2] = 2'(c);
        r[3] = 2'(d);
        return r;
    endfunction

    // Output = sorted input; swaps = inversion count; with early exit the run stops after
    // the first swap-free pass, and pass k swaps iff some word has more than k larger words before it.
    task automatic model(input blk_t w, output blk_t e, output int sw, output int cyc);
        int q[$];
        int m, c, passes;
        sw = 0;
        m = 0;
        for (int i = 0; i < 4; i++) begin
            q.push_back(int'(w[i]));
            c = 0;
            for (int k = 0; k < i; k++) if (w[k] > w[i]) c++;
            sw += c;
            if (c > m) m = c;
        end
        q.sort();
        for (int i = 0; i < 4; i++) e[i] = 2'(q[i]);
        passes = early ? ((m + 1 < 3) ? m + 1 : 3) : 3;
        cyc = 0;
        for (int k = 0; k < passes; k++) cyc += 3 - k;
    endtask

    task automatic run_block(input string nm, input blk_t w, input blk_t e, input int sw,
                             input int cyc, input int stall, input int start, input bit junk);
        int n;
        for (int i = start; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = w[i];
        end
        @(negedge clk);
        if (junk) in_data = 2'd2;
        else in_valid = 1'b0;
        check({nm, " cmp_first"}, int'(cmp_out), int'({w[0] > w[1], w[0] == w[1], w[0] < w[1]}));
        n = 0;
        while (busy && n < 200) begin
            check({nm, " in_ready_sort"}, int'(in_ready), 0);
            n++;
            @(negedge clk);
        end
        check({nm, " busy_cycles"}, n, cyc);
        check({nm, " swap_count"}, int'(swap_count), sw);
        check({nm, " cmp_out_idle"}, int'(cmp_out), 0);
        for (int k = 0; k < 4; k++) begin
            if (k == stall) begin
                out_ready = 1'b0;
                repeat (2) begin
                    check({nm, " hold_data"}, int'(out_data), int'(e[k]));
                    check({nm, " hold_valid"}, int'(out_valid), 1);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            if (junk) check({nm, " in_ready_out"}, int'(in_ready), 0);
            check({nm, " out_valid"}, int'(out_valid), 1);
            check({nm, " out_data"}, int'(out_data), int'(e[k]));
            @(negedge clk);
        end
        check({nm, " end_in_ready"}, int'(in_ready), 1);
        check({nm, " end_out_valid"}, int'(out_valid), 0);
        check({nm, " end_swap_hold"}, int'(swap_count), sw);
    endtask

    initial begin
        blk_t w, e;
        int sw, cyc;
        tbl[0] = '{"reverse", mk(3, 2, 1, 0), mk(0, 1, 2, 3), 6, 6, 1};
        tbl[1] = '{"sorted",  mk(0, 1, 2, 3), mk(0, 1, 2, 3), 0, early ? 3 : 6, -1};
        tbl[2] = '{"dupes",   mk(3, 3, 0, 0), mk(0, 0, 3, 3), 4, 6, -1};
        tbl[3] = '{"mixed",   mk(2, 0, 3, 1), mk(0, 1, 2, 3), 3, 6, 2};
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        #3;
        check("rst in_ready", int'(in_ready), 1);
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_data", int'(out_data), 0);
        check("rst busy", int'(busy), 0);
        check("rst cmp_out", int'(cmp_out), 0);
        check("rst swap_count", int'(swap_count), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) run_block(tbl[i].nm, tbl[i].w, tbl[i].e, tbl[i].sw, tbl[i].cyc, tbl[i].stall, 0, 1'b0);

        // Word held on in_data during SORT/OUT becomes the first word of the next block.
        w = mk(1, 0, 3, 2);
        model(w, e, sw, cyc);
        run_block("junk", w, e, sw, cyc, -1, 0, 1'b1);
        w = mk(2, 3, 0, 1);
        model(w, e, sw, cyc);
        run_block("after_junk", w, e, sw, cyc, -1, 1, 1'b0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 2'(3 - i);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst in_ready", int'(in_ready), 1);
        check("midrst out_valid", int'(out_valid), 0);
        check("midrst busy", int'(busy), 0);
        check("midrst swap_count", int'(swap_count), 0);
        check("midrst cmp_out", int'(cmp_out), 0);
        check("midrst out_data", int'(out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        run_block("after_rst", mk(2, 0, 3, 1), mk(0, 1, 2, 3), 3, 6, -1, 0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            w = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            model(w, e, sw, cyc);
            run_block("random", w, e, sw, cyc, int'($urandom_range(0, 5)) - 1, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cmp_sort_ctrl.md
# cmp_sort_ctrl

Sequential sorting controller that time-shares a single magnitude-compare unit to sort a block of DEPTH unsigned words. Words are loaded over a valid/ready input port and sorted in place by bubble sort, one compare-and-swap per cycle. Results are then streamed out in ascending order over a valid/ready output port. It sits in front of the comparator datapath as its sequencer and is the first block in the codebase to use clocked control around the comparator.

## Interface
- WIDTH, 2: data word width in bits; unsigned; must be ≥ 1
- DEPTH, 4: words per sort block; must be ≥ 2 and ≤ 16
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts a word this cycle
- in_data  input  WIDTH  word to load
- out_valid  output  1  out_data holds a sorted word
- out_ready  input  1  consumer accepts out_data
- out_data  output  WIDTH  sorted word, ascending order
- busy  output  1  high in SORT state
- cmp_out  output  3  {gt, eq, lt} of the current compare operands; 3'b000 outside SORT
- swap_count  output  8  swaps performed in the current block; saturates at 255

## Operation
- States: LOAD, SORT, OUT. Reset state is LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid && in_ready, write mem[wr_idx]=in_data and increment wr_idx.
  - The DEPTH-th accept moves to SORT, clears pass index p, compare index j and the pass-swap flag, and clears swap_count.
- SORT:
  - in_ready=0. One compare per cycle: A=mem[j], B=mem[j+1].
  - cmp_out = {A>B, A==B, A<B}, unsigned.
  - If gt: swap the entries, increment swap_count (saturating), set the pass-swap flag.
  - eq or lt: no swap. Equal words keep their order, so the sort is stable.
  - j runs 0..DEPTH-2-p. At the end of a pass: p increments, j=0, and the pass-swap flag clears.
  - After pass p=DEPTH-2 completes, move to OUT with rd_idx=0.
- OUT:
  - out_valid=1, out_data=mem[rd_idx].
  - On out_valid && out_ready, increment rd_idx.
  - The DEPTH-th transfer moves to LOAD with wr_idx=0.
  - swap_count holds its value until the next SORT entry.
- In_valid outside LOAD is ignored. The word is not absorbed; the producer must hold it.
- Out_ready outside OUT is ignored.
- Arithmetic:
  - Indices are $clog2(DEPTH) bits, with no wrap-around past DEPTH-1.
  - The comparison is full WIDTH unsigned, with no sign extension.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0 (mem cleared to 0), busy=0, cmp_out=3'b000, swap_count=0, state LOAD, all indices 0.
- Asserting rst in any state, including mid-SORT or mid-OUT, returns these values immediately (asynchronous). The partial block is discarded.
- Load: minimum DEPTH cycles. SORT is entered on the cycle after the last accept.
- Sort latency without the early-exit feature: exactly DEPTH(DEPTH-1)/2 cycles in SORT, which is 6 for DEPTH=4, independent of the data.
- Output: out_data is stable while out_valid && !out_ready. There is no combinational path from out_ready to out_data.
- All outputs are registered or decoded from state and registers. There is no combinational path from in_valid to in_ready.

## Configuration
- Macro: CMP_SORT_EARLY_EXIT_EN.
- Defined: at the end of any pass with the pass-swap flag clear, move directly to OUT. Remaining passes are skipped.
  - Already-sorted input therefore spends DEPTH-1 cycles in SORT.
  - Worst case is unchanged.
- Undefined: all DEPTH-1 passes always run, giving fixed latency.
- Sorted output is identical in both builds.

## Test plan
All scenarios use WIDTH=2, DEPTH=4.
- Reverse order: load 3,2,1,0 -> busy high for exactly 6 cycles; output 0,1,2,3; swap_count=6.
- Pre-sorted input: load 0,1,2,3 -> output 0,1,2,3, swap_count=0. With CMP_SORT_EARLY_EXIT_EN, busy lasts 3 cycles; without it, 6 cycles.
- Duplicates: load 3,3,0,0 -> output 0,0,3,3; swap_count=4; cmp_out=3'b010 on the first compare.
- Output backpressure: hold out_ready low for 2 cycles after the second word is presented -> out_data holds that word, no word is skipped or repeated, and the 4 words complete in order.
- Input during SORT/OUT: drive in_valid=1 with in_data=2 throughout -> in_ready=0; the word is not loaded until the next LOAD; the current block's output is unaffected.
- Reset mid-SORT: assert rst after the 3rd sort cycle -> in_ready=1, out_valid=0, busy=0, swap_count=0 immediately; a fresh load of 2,0,3,1 then sorts to 0,1,2,3.
